// File: rtl/burst_rom.sv
// ----------------------------------------------------------------------------
// burst_rom
//   Constant lookup ROM holding an arithmetic sequence
//   ROM[i] = (BASE + STEP*i) mod 2^DATA_W for i = 0..DEPTH-1.
//   It accepts one request at a time through a valid/ready handshake.
//   It then streams (req_len + 1) words, starting at req_addr, one word per
//   cycle. The address wraps from DEPTH-1 back to 0. A start address at or
//   above DEPTH gives a single error beat with zero data.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   i_req_valid   in   request present
//   o_req_ready   out  block is idle and can accept a request
//   i_req_addr    in   burst start address            [ADDR_W]
//   i_req_len     in   beats minus one (0 = single)   [ADDR_W]
//   o_rsp_valid   out  response word valid
//   i_rsp_ready   in   consumer accepts the word
//   o_rsp_data    out  ROM word                       [DATA_W]
//   o_rsp_last    out  final beat of the burst
//   o_rsp_err     out  start address was out of range
//   o_busy        out  burst in progress (state != IDLE)
// ----------------------------------------------------------------------------
module burst_rom #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int BASE   = 0,
   parameter int STEP   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [ADDR_W-1:0] i_req_len,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_last,
   output logic              o_rsp_err,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_LAST   = 2'd2
   } state_t;

   // The table is padded to a power of two so any ADDR_W-bit pointer indexes it
   // safely. Entries at DEPTH and above are never read as data.
   localparam int              ROM_N   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

   // Table entry value. The value is computed in integer width, then truncated.
   function automatic logic [DATA_W-1:0] rom_entry(input int idx);
      int v;
      v = BASE + STEP * idx;
      return DATA_W'(v);
   endfunction

   // Pointer increment. The pointer wraps at DEPTH, not at 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] x);
      logic [ADDR_W:0] n;
      n = {1'b0, x} + (ADDR_W + 1)'(1);
      if (n == L_DEPTH) begin
         return '0;
      end else begin
         return n[ADDR_W-1:0];
      end
   endfunction

   logic [DATA_W-1:0] w_rom [ROM_N];

   for (genvar g = 0; g < ROM_N; g++) begin : g_rom
      if (g < DEPTH) begin : g_used
         assign w_rom[g] = rom_entry(g);
      end else begin : g_pad
         assign w_rom[g] = '0;
      end
   end

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_rem;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_last;
   logic              r_rsp_err;

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic [ADDR_W-1:0] w_rem_nxt;
   logic              w_valid_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_last_nxt;
   logic              w_err_nxt;
   logic              w_in_range;

   assign w_in_range = ({1'b0, i_req_addr} < L_DEPTH);

   // Next-state and next-datapath logic. Every register holds unless a
   // handshake occurs.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_rem_nxt   = r_rem;
      w_valid_nxt = r_rsp_valid;
      w_data_nxt  = r_rsp_data;
      w_last_nxt  = r_rsp_last;
      w_err_nxt   = r_rsp_err;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_valid_nxt = 1'b1;
               if (w_in_range) begin
                  w_data_nxt  = w_rom[i_req_addr];
                  w_err_nxt   = 1'b0;
                  w_last_nxt  = (i_req_len == '0);
                  w_ptr_nxt   = wrap_inc(i_req_addr);
                  // rem underflows for len==0. It is never used because
                  // the block goes straight to LAST in that case.
                  w_rem_nxt   = i_req_len - ADDR_W'(1);
                  w_state_nxt = (i_req_len == '0) ? S_LAST : S_STREAM;
               end else begin
                  w_data_nxt  = '0;
                  w_err_nxt   = 1'b1;
                  w_last_nxt  = 1'b1;
                  w_state_nxt = S_LAST;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STREAM: begin
            if (i_rsp_ready) begin
               w_data_nxt = w_rom[r_ptr];
               w_last_nxt = (r_rem == '0);
               w_ptr_nxt  = wrap_inc(r_ptr);
               w_rem_nxt  = r_rem - ADDR_W'(1);
               if (r_rem == '0) begin
                  w_state_nxt = S_LAST;
               end else begin
                  w_state_nxt = S_STREAM;
               end
            end else begin
               w_state_nxt = S_STREAM;
            end
         end
         S_LAST: begin
            if (i_rsp_ready) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = 1'b0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_LAST;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_rem       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_ptr       <= w_ptr_nxt;
         r_rem       <= w_rem_nxt;
         r_rsp_valid <= w_valid_nxt;
         r_rsp_data  <= w_data_nxt;
         r_rsp_last  <= w_last_nxt;
         r_rsp_err   <= w_err_nxt;
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_last  = r_rsp_last;
   assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_burst_rom.sv
// ----------------------------------------------------------------------------
// tb_burst_rom
//   Directed bench for burst_rom. It uses three instances:
//     a : default parameters
//     b : DEPTH = 12
//     c : DATA_W = 4, BASE = 3, STEP = 5
//   Inputs are driven and outputs are sampled 1 time unit after each rising
//   clock edge.
// ----------------------------------------------------------------------------
module tb_burst_rom;

   logic clk;
   logic rst_n;

   logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
   logic       a_rsp_last, a_rsp_err, a_busy;
   logic [3:0] a_req_addr, a_req_len;
   logic [7:0] a_rsp_data;

   logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic       b_rsp_last, b_rsp_err, b_busy;
   logic [3:0] b_req_addr, b_req_len;
   logic [7:0] b_rsp_data;

   logic       c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready;
   logic       c_rsp_last, c_rsp_err, c_busy;
   logic [3:0] c_req_addr, c_req_len;
   logic [3:0] c_rsp_data;

   int checks = 0;
   int errors = 0;

   burst_rom u_a (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
      .i_req_addr(a_req_addr), .i_req_len(a_req_len),
      .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
      .o_rsp_data(a_rsp_data), .o_rsp_last(a_rsp_last),
      .o_rsp_err(a_rsp_err), .o_busy(a_busy)
   );

   burst_rom #(.DEPTH(12)) u_b (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
      .i_req_addr(b_req_addr), .i_req_len(b_req_len),
      .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
      .o_rsp_data(b_rsp_data), .o_rsp_last(b_rsp_last),
      .o_rsp_err(b_rsp_err), .o_busy(b_busy)
   );

   burst_rom #(.DATA_W(4), .BASE(3), .STEP(5)) u_c (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(c_req_valid), .o_req_ready(c_req_ready),
      .i_req_addr(c_req_addr), .i_req_len(c_req_len),
      .o_rsp_valid(c_rsp_valid), .i_rsp_ready(c_rsp_ready),
      .o_rsp_data(c_rsp_data), .o_rsp_last(c_rsp_last),
      .o_rsp_err(c_rsp_err), .o_busy(c_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   logic [7:0]  bp_got [8];
   int          bp_n;
   int          bp_lasts;
   logic [7:0]  prev_d;
   logic        prev_l;
   logic        fire;
   logic [7:0]  pat;
   logic [31:0] exp_wrap [4];
   logic [31:0] exp_b [3];

   initial begin
      rst_n = 1'b0;
      a_req_valid = 1'b0; a_req_addr = 4'd0; a_req_len = 4'd0; a_rsp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_addr = 4'd0; b_req_len = 4'd0; b_rsp_ready = 1'b0;
      c_req_valid = 1'b0; c_req_addr = 4'd0; c_req_len = 4'd0; c_rsp_ready = 1'b0;
      repeat (2) tick();

      // Reset state
      chk("rst_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_data",  32'(a_rsp_data),  32'd0);
      chk("rst_last",  32'(a_rsp_last),  32'd0);
      chk("rst_err",   32'(a_rsp_err),   32'd0);
      chk("rst_busy",  32'(a_busy),      32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_ready", 32'(a_req_ready), 32'd1);

      // Single read addr=5 len=0
      a_req_valid = 1'b1; a_req_addr = 4'd5; a_req_len = 4'd0; a_rsp_ready = 1'b1;
      tick();
      a_req_valid = 1'b0;
      chk("single_valid", 32'(a_rsp_valid), 32'd1);
      chk("single_data",  32'(a_rsp_data),  32'd10);
      chk("single_last",  32'(a_rsp_last),  32'd1);
      chk("single_err",   32'(a_rsp_err),   32'd0);
      chk("single_busy",  32'(a_busy),      32'd1);
      chk("single_ready", 32'(a_req_ready), 32'd0);
      tick();
      chk("single_done_valid", 32'(a_rsp_valid), 32'd0);
      chk("single_done_ready", 32'(a_req_ready), 32'd1);
      chk("single_done_last",  32'(a_rsp_last),  32'd0);

      // Wrapping burst addr=14 len=3
      exp_wrap[0] = 32'd28; exp_wrap[1] = 32'd30; exp_wrap[2] = 32'd0; exp_wrap[3] = 32'd2;
      a_req_valid = 1'b1; a_req_addr = 4'd14; a_req_len = 4'd3;
      tick();
      a_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_valid%0d", i), 32'(a_rsp_valid), 32'd1);
         chk($sformatf("wrap_data%0d", i),  32'(a_rsp_data),  exp_wrap[i]);
         chk($sformatf("wrap_last%0d", i),  32'(a_rsp_last),  (i == 3) ? 32'd1 : 32'd0);
         tick();
      end
      chk("wrap_end_valid", 32'(a_rsp_valid), 32'd0);
      chk("wrap_end_ready", 32'(a_req_ready), 32'd1);

      // Backpressure burst addr=0 len=4, ready pattern 1,0,0,1,0,1,1,1
      pat = 8'b1110_1001;  // bit i is the ready value in cycle i
      bp_n = 0;
      bp_lasts = 0;
      a_req_valid = 1'b1; a_req_addr = 4'd0; a_req_len = 4'd4;
      tick();
      a_req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_rsp_ready = pat[i];
         prev_d = a_rsp_data;
         prev_l = a_rsp_last;
         fire = a_rsp_valid && pat[i];
         if (fire) begin
            if (bp_n < 8) bp_got[bp_n] = a_rsp_data;
            bp_n++;
            if (a_rsp_last) bp_lasts++;
         end
         tick();
         if (!fire) begin
            chk($sformatf("bp_hold_data%0d", i), 32'(a_rsp_data), 32'(prev_d));
            chk($sformatf("bp_hold_last%0d", i), 32'(a_rsp_last), 32'(prev_l));
            chk($sformatf("bp_hold_valid%0d", i), 32'(a_rsp_valid), 32'd1);
         end
      end
      chk("bp_count", 32'(bp_n), 32'd5);
      chk("bp_lasts", 32'(bp_lasts), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_data%0d", i), 32'(bp_got[i]), 32'(2 * i));
      end
      chk("bp_end_valid", 32'(a_rsp_valid), 32'd0);

      // Reset mid-stream
      a_rsp_ready = 1'b1;
      a_req_valid = 1'b1; a_req_addr = 4'd0; a_req_len = 4'd7;
      tick();
      a_req_valid = 1'b0;
      tick();
      tick();
      chk("mid_valid", 32'(a_rsp_valid), 32'd1);
      chk("mid_data",  32'(a_rsp_data),  32'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
      chk("mid_rst_data",  32'(a_rsp_data),  32'd0);
      chk("mid_rst_busy",  32'(a_busy),      32'd0);
      chk("mid_rst_last",  32'(a_rsp_last),  32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst_valid%0d", i), 32'(a_rsp_valid), 32'd0);
         chk($sformatf("post_rst_ready%0d", i), 32'(a_req_ready), 32'd1);
      end

      // DEPTH=12: out-of-range addr=13 len=5
      b_rsp_ready = 1'b1;
      b_req_valid = 1'b1; b_req_addr = 4'd13; b_req_len = 4'd5;
      tick();
      b_req_valid = 1'b0;
      chk("oor_valid", 32'(b_rsp_valid), 32'd1);
      chk("oor_data",  32'(b_rsp_data),  32'd0);
      chk("oor_err",   32'(b_rsp_err),   32'd1);
      chk("oor_last",  32'(b_rsp_last),  32'd1);
      tick();
      chk("oor_end_valid", 32'(b_rsp_valid), 32'd0);
      chk("oor_end_err",   32'(b_rsp_err),   32'd0);

      // DEPTH=12: addr == DEPTH is also out of range
      b_req_valid = 1'b1; b_req_addr = 4'd12; b_req_len = 4'd0;
      tick();
      b_req_valid = 1'b0;
      chk("edge_err", 32'(b_rsp_err), 32'd1);
      tick();

      // DEPTH=12: addr=10 len=2 wraps at 12
      exp_b[0] = 32'd20; exp_b[1] = 32'd22; exp_b[2] = 32'd0;
      b_req_valid = 1'b1; b_req_addr = 4'd10; b_req_len = 4'd2;
      tick();
      b_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d12_data%0d", i), 32'(b_rsp_data), exp_b[i]);
         chk($sformatf("d12_err%0d", i),  32'(b_rsp_err),  32'd0);
         chk($sformatf("d12_last%0d", i), 32'(b_rsp_last), (i == 2) ? 32'd1 : 32'd0);
         tick();
      end
      chk("d12_end_valid", 32'(b_rsp_valid), 32'd0);

      // DATA_W=4 BASE=3 STEP=5: addr=3 len=1 -> 18 mod 16 = 2, then 23 mod 16 = 7
      c_rsp_ready = 1'b1;
      c_req_valid = 1'b1; c_req_addr = 4'd3; c_req_len = 4'd1;
      tick();
      c_req_valid = 1'b0;
      chk("trunc_data0", 32'(c_rsp_data), 32'd2);
      chk("trunc_last0", 32'(c_rsp_last), 32'd0);
      tick();
      chk("trunc_data1", 32'(c_rsp_data), 32'd7);
      chk("trunc_last1", 32'(c_rsp_last), 32'd1);
      tick();
      chk("trunc_end_valid", 32'(c_rsp_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
